store_align_buffer: RTL and testbench
=====================================

// Module: store_align_buffer
// PURPOSE
//   Store-side counterpart of the load data-extension path: aligns RV32I SB/SH/SW
//   data into byte lanes and generates byte enables. Buffers stores in a small
//   FIFO and drains them to the data cache over a req/ack handshake.
//   Sits between the MEM stage and the data cache write port. Flags misaligned
//   stores, and flags loads that hit a buffered word.
// PARAMETERS
//   DEPTH   4   store buffer entries (power of 2, >=2)
//   CNT_W   3   width of count output; must hold 0..DEPTH
// PORTS
//   clk          in   1   core clock; all state updates on rising edge
//   rst          in   1   synchronous reset, active-high
//   st_valid     in   1   MEM stage presents a store this cycle
//   st_type      in   2   00 none, 01 SB, 10 SH, 11 SW
//   st_addr      in   32  byte address of store
//   st_data      in   32  rs2 value, unaligned (low bits significant)
//   st_ready     out  1   buffer can accept a store this cycle (= count!=DEPTH)
//   misalign     out  1   store rejected: misaligned address
//   ld_check     in   1   MEM stage presents a load this cycle
//   ld_addr      in   32  byte address of load
//   ld_conflict  out  1   load word matches a buffered store; pipeline must stall
//   wr_req       out  1   cache write request
//   wr_addr      out  32  word-aligned write address {addr[31:2],2'b00}
//   wr_data      out  32  lane-aligned write data
//   wr_be        out  4   byte enables, bit i = byte lane i
//   wr_ack       in   1   cache accepted the write this cycle
//   empty        out  1   no entries buffered
//   count        out  CNT_W number of valid entries (includes in-flight head)
// BEHAVIOUR
//   Reset (sync): count=0, rd/wr pointers=0, FSM=IDLE. wr_req=0, empty=1,
//     st_ready=1, ld_conflict=0. A request in flight is dropped next cycle and
//     all entries are discarded. wr_ack is ignored while rst=1.
//   Alignment (combinational on push), a=st_addr[1:0]:
//     SB: data = {24'b0,st_data[7:0]} << 8*a; be = 4'b0001 << a
//     SH: data = {16'b0,st_data[15:0]} << 16*a[1]; be = 4'b0011 << 2*a[1]
//     SW: data = st_data; be = 4'b1111
//     Non-enabled lanes are 0.
//   misalign = st_valid & ((SH & a[0]) | (SW & a!=0)); combinational.
//     A misaligned store is never enqueued.
//   push = st_valid & st_type!=00 & ~misalign & st_ready. Pushed at the clock edge
//     ending that cycle. st_type=00 is ignored and never sets misalign.
//   A store while full is not accepted; the MEM stage must hold it until st_ready=1.
//   Drain FSM:
//     IDLE: goes to REQ if count!=0.
//     REQ: wr_req=1. wr_addr/wr_data/wr_be come from the head entry and hold
//       stable until wr_ack. On wr_ack: pop the head, go to IDLE.
//     wr_req is low for at least one cycle between requests.
//   Latency: push accepted in cycle N -> wr_req high in cycle N+2 (buffer was
//     empty and IDLE). Ack in cycle M -> next wr_req in cycle M+2.
//   Simultaneous push and pop: both happen; count is unchanged. A push while
//     full, even with wr_ack in the same cycle, is refused (st_ready uses
//     registered count).
//   Pointers wrap modulo DEPTH. FIFO order is strict; no write combining.
//   ld_conflict = ld_check & any valid entry with addr[31:2]==ld_addr[31:2].
//     Includes the in-flight head; excludes a store pushed the same cycle.
//     Combinational.
//   empty = (count==0); registered-state derived.
// TESTING
//   1 SB addr=0x1003 data=0xAB, ack 1 cycle after req -> wr_req in cycle N+2,
//     wr_addr=0x1000, wr_data=0xAB000000, wr_be=1000; empty=1 after ack.
//   2 SH addr=0x2002 data=0x1234 then SW 0x2008 data=0xDEADBEEF -> two reqs in
//     order: (0x2000, 0x12340000, 1100) then (0x2008, 0xDEADBEEF, 1111).
//   3 SH addr=0x3001 and SW addr=0x3002 -> misalign=1 each cycle, count stays 0,
//     no wr_req.
//   4 wr_ack held 0, push 5 SW stores -> st_ready=0 after 4th, count=4, 5th
//     refused. Then ack in the same cycle as the 5th push attempt -> count=3,
//     5th still refused. It is accepted once presented again with st_ready=1.
//   5 buffer holds SB 0x4005; ld_check with ld_addr=0x4007 -> ld_conflict=1.
//     With ld_addr=0x4008 -> ld_conflict=0. After its ack -> 0x4007 gives 0.
//   6 rst=1 while wr_req=1 and count=3 -> next cycle wr_req=0, count=0, empty=1;
//     no further requests.

Source files
------------

// File: rtl/store_align_buffer_if.sv
// Store-buffer bus bundle: MEM-stage store/load port toward the buffer and the
// cache write port out of it, plus the drain FSM state for observation.
interface store_align_buffer_if #(
    parameter int CNT_W = 3
);
    // Handshakes: a store transfers on the rising edge where st_valid and st_ready
    // are both high; wr_req holds wr_addr/wr_data/wr_be stable until the edge
    // where wr_ack is high, which retires that write.
    logic             st_valid;
    logic [1:0]       st_type;
    logic [31:0]      st_addr;
    logic [31:0]      st_data;
    logic             st_ready;
    logic             misalign;
    logic             ld_check;
    logic [31:0]      ld_addr;
    logic             ld_conflict;
    logic             wr_req;
    logic [31:0]      wr_addr;
    logic [31:0]      wr_data;
    logic [3:0]       wr_be;
    logic             wr_ack;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             state_dbg;

    modport master (
        output st_valid, st_type, st_addr, st_data, ld_check, ld_addr, wr_ack,
        input  st_ready, misalign, ld_conflict, wr_req, wr_addr, wr_data, wr_be,
               empty, count, state_dbg
    );

    modport slave (
        input  st_valid, st_type, st_addr, st_data, ld_check, ld_addr, wr_ack,
        output st_ready, misalign, ld_conflict, wr_req, wr_addr, wr_data, wr_be,
               empty, count, state_dbg
    );
endinterface

// File: rtl/store_align_buffer.sv
// RV32I store aligner plus a small in-order store buffer drained to the data
// cache one write at a time over wr_req/wr_ack.
module store_align_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    store_align_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {IDLE, REQ} drain_state_t;

    drain_state_t     state, state_nx;
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic [DEPTH-1:0] ent_vld;
    logic [29:0]      ent_addr [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [3:0]       ent_be   [DEPTH];

    logic [1:0]  a;
    logic [31:0] al_data;
    logic [3:0]  al_be;
    logic        mis, rdy, push, pop, hit;
    logic        unused_ld_low;

    assign a = bus.st_addr[1:0];

    always_comb begin
        al_data = '0;
        al_be   = '0;
        case (bus.st_type)
            2'b01: begin
                al_data = {24'b0, bus.st_data[7:0]} << {a, 3'b000};
                al_be   = 4'b0001 << a;
            end
            2'b10: begin
                al_data = {16'b0, bus.st_data[15:0]} << {a[1], 4'b0000};
                al_be   = 4'b0011 << {a[1], 1'b0};
            end
            2'b11: begin
                al_data = bus.st_data;
                al_be   = 4'b1111;
            end
            default: ;
        endcase
    end

    assign mis  = bus.st_valid & (((bus.st_type == 2'b10) & a[0]) |
                                  ((bus.st_type == 2'b11) & (a != 2'b00)));
    // Readiness uses registered count only, so a same-cycle ack never frees a slot.
    assign rdy  = (cnt != CNT_W'(DEPTH));
    assign push = bus.st_valid & (bus.st_type != 2'b00) & ~mis & rdy;
    assign pop  = (state == REQ) & bus.wr_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            ent_vld <= '0;
        end else begin
            if (pop) begin
                rd_ptr          <= rd_ptr + 1'b1;
                ent_vld[rd_ptr] <= 1'b0;
            end
            if (push) begin
                wr_ptr          <= wr_ptr + 1'b1;
                ent_vld[wr_ptr] <= 1'b1;
            end
            cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[wr_ptr] <= bus.st_addr[31:2];
            ent_data[wr_ptr] <= al_data;
            ent_be[wr_ptr]   <= al_be;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Returning to IDLE after every ack guarantees a gap cycle between requests.
    always_comb begin
        state_nx   = state;
        bus.wr_req = 1'b0;
        case (state)
            IDLE: if (cnt != '0) state_nx = REQ;
            REQ: begin
                bus.wr_req = 1'b1;
                if (bus.wr_ack) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (ent_addr[i] == bus.ld_addr[31:2])) hit = 1'b1;
        end
    end

    assign unused_ld_low   = ^bus.ld_addr[1:0];
    assign bus.ld_conflict = bus.ld_check & hit;
    assign bus.st_ready    = rdy;
    assign bus.misalign    = mis;
    assign bus.wr_addr     = {ent_addr[rd_ptr], 2'b00};
    assign bus.wr_data     = ent_data[rd_ptr];
    assign bus.wr_be       = ent_be[rd_ptr];
    assign bus.empty       = (cnt == '0);
    assign bus.count       = cnt;
    assign bus.state_dbg   = (state == REQ);
endmodule

// File: tb/tb_store_align_buffer.sv
// Directed and random stimulus for store_align_buffer; cache writes are checked
// against an expected queue filled as stores are presented.
module tb_store_align_buffer;
  localparam int W = 68;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   ack_en = 1'b0;
  int   age = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [W-1:0] exp_q[$];

  store_align_buffer_if #(.CNT_W(3)) bif ();

  store_align_buffer #(.DEPTH(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] t, input logic [31:0] ad,
                                         input logic [31:0] d);
    logic [31:0] wd;
    logic [3:0]  be;
    int          lane;
    wd = '0;
    be = '0;
    lane = int'(ad[1:0]);
    if (t == 2'b01) begin
      be[lane] = 1'b1;
      wd[8*lane +: 8] = d[7:0];
    end else if (t == 2'b10) begin
      lane = ad[1] ? 2 : 0;
      be[lane] = 1'b1;
      be[lane+1] = 1'b1;
      wd[8*lane +: 16] = d[15:0];
    end else if (t == 2'b11) begin
      be = 4'hf;
      wd = d;
    end
    return {ad[31:2], 2'b00, wd, be};
  endfunction

  function automatic bit model_mis(input logic [1:0] t, input logic [31:0] ad);
    return (t == 2'b10 && ad[0]) || (t == 2'b11 && ad[1:0] != 2'b00);
  endfunction

  // ---------------- cache-side ack driver ----------------
  initial begin
    bif.wr_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ack_en) bif.wr_ack = bif.wr_req && (age >= 1);
      if (bif.wr_req) age++;
      else age = 0;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (!rst && bif.wr_req && bif.wr_ack) begin
      if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
      else check("wr_txn", {bif.wr_addr, bif.wr_data, bif.wr_be}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic store(input logic [1:0] t, input logic [31:0] ad, input logic [31:0] d,
                       input bit exp_rdy, input bit exp_mis, input logic [W-1:0] exp_wr);
    @(posedge clk);
    #1;
    bif.st_valid = 1'b1;
    bif.st_type  = t;
    bif.st_addr  = ad;
    bif.st_data  = d;
    @(negedge clk);
    check("st_ready", bif.st_ready, exp_rdy);
    check("misalign", bif.misalign, exp_mis);
    if (exp_rdy && !exp_mis && t != 2'b00) exp_q.push_back(exp_wr);
  endtask

  task automatic st_off();
    @(posedge clk);
    #1;
    bif.st_valid = 1'b0;
    bif.st_type  = 2'b00;
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bif.empty && !bif.wr_req) break;
    end
    check(tag, {bif.empty, bif.wr_req}, {1'b1, 1'b0});
    check("sb_left", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  t;
    logic [31:0] ad, d;
    bit          m, any_req;

    bif.st_valid = 1'b0;
    bif.st_type  = 2'b00;
    bif.st_addr  = '0;
    bif.st_data  = '0;
    bif.ld_check = 1'b1;
    bif.ld_addr  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", {bif.wr_req, bif.empty, bif.st_ready, bif.ld_conflict, bif.count},
          {1'b0, 1'b1, 1'b1, 1'b0, 3'd0});
    @(posedge clk);
    #1;
    rst = 1'b0;
    bif.ld_check = 1'b0;

    // SB with lane-3 placement and push->req latency
    ack_en = 1'b1;
    store(2'b01, 32'h1003, 32'h0000_00AB, 1, 0, {32'h1000, 32'hAB00_0000, 4'b1000});
    st_off();
    @(negedge clk);
    check("lat_n1", bif.wr_req, 0);
    @(negedge clk);
    check("lat_n2", bif.wr_req, 1);
    wait_empty("t1_drain");

    // SH then SW, strict order
    store(2'b10, 32'h2002, 32'h0000_1234, 1, 0, {32'h2000, 32'h1234_0000, 4'b1100});
    store(2'b11, 32'h2008, 32'hDEAD_BEEF, 1, 0, {32'h2008, 32'hDEAD_BEEF, 4'b1111});
    st_off();
    wait_empty("t2_drain");

    // misaligned stores are rejected
    store(2'b10, 32'h3001, 32'h0000_5555, 1, 1, '0);
    store(2'b11, 32'h3002, 32'h6666_6666, 1, 1, '0);
    store(2'b00, 32'h3003, 32'h7777_7777, 1, 0, '0);
    st_off();
    any_req = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bif.wr_req || bif.count != 0) any_req = 1'b1;
    end
    check("t3_nothing_queued", any_req, 0);

    // fill, refuse when full, same-cycle ack does not free a slot
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ad = 32'h5000 + 32'(4 * i);
      d  = 32'hC0DE_0000 + 32'(i);
      store(2'b11, ad, d, 1, 0, {ad, d, 4'hf});
    end
    store(2'b11, 32'h5010, 32'hC0DE_0004, 0, 0, '0);
    check("t4_count_full", bif.count, 4);
    @(posedge clk);
    #1;
    bif.wr_ack = 1'b1;
    @(negedge clk);
    check("t4_ready_ack_cycle", {bif.st_ready, bif.wr_req}, {1'b0, 1'b1});
    @(posedge clk);
    #1;
    bif.wr_ack = 1'b0;
    @(negedge clk);
    check("t4_count_after_ack", {bif.count, bif.st_ready}, {3'd3, 1'b1});
    exp_q.push_back({32'h5010, 32'hC0DE_0004, 4'hf});
    st_off();
    @(negedge clk);
    check("t4_count_refill", bif.count, 4);
    ack_en = 1'b1;
    wait_empty("t4_drain");

    // load conflict against a buffered word
    ack_en = 1'b0;
    store(2'b01, 32'h4005, 32'h0000_0077, 1, 0, {32'h4004, 32'h0000_7700, 4'b0010});
    st_off();
    bif.ld_check = 1'b1;
    bif.ld_addr  = 32'h4007;
    @(negedge clk);
    check("t5_conflict_hit", bif.ld_conflict, 1);
    @(posedge clk);
    #1;
    bif.ld_addr = 32'h4008;
    @(negedge clk);
    check("t5_conflict_miss", bif.ld_conflict, 0);
    ack_en = 1'b1;
    wait_empty("t5_drain");
    bif.ld_addr = 32'h4007;
    @(negedge clk);
    check("t5_conflict_after", bif.ld_conflict, 0);
    bif.ld_check = 1'b0;

    // reset while a request is in flight
    ack_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ad = 32'h6000 + 32'(4 * i);
      store(2'b11, ad, ad, 1, 0, {ad, ad, 4'hf});
    end
    st_off();
    repeat (2) @(negedge clk);
    check("t6_pre_rst", {bif.wr_req, bif.count}, {1'b1, 3'd3});
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_post_rst", {bif.wr_req, bif.count, bif.empty}, {1'b0, 3'd0, 1'b1});
    any_req = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bif.wr_req) any_req = 1'b1;
    end
    check("t6_no_req", any_req, 0);

    // random single stores across all types and offsets
    ack_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      t  = 2'($urandom_range(1, 3));
      ad = $urandom;
      d  = $urandom;
      m  = model_mis(t, ad);
      store(t, ad, d, 1, m, model(t, ad, d));
      st_off();
      if (!m) wait_empty("rnd_drain");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
